// File: rtl/rgb_src_pkg.sv
// Shared encodings for the RGB test-source frame controller.
// Combinational only; no flow control of its own.
package rgb_src_pkg;

    typedef enum logic [1:0] {
        OP_STOP       = 2'd0,
        OP_RUN_AUTO   = 2'd1,
        OP_RUN_MANUAL = 2'd2,
        OP_STEP       = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        AUTO   = 2'd2,
        MANUAL = 2'd3
    } state_e;

endpackage

// File: rtl/rgb_frame_tick.sv
// Frame-start detector (fs one cycle after the VSA edge) plus a saturating frame watchdog.
// Sticky timeout flag, cleared only by err_clr or reset; no backpressure.
module rgb_frame_tick #(
    parameter int VS_POL  = 1,
    parameter int TIMEOUT = 2000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vsa,
    input  logic run,
    input  logic err_clr,
    output logic fs,
    output logic timeout_err
);
    localparam int             WW     = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0]  WD_MAX = WW'(TIMEOUT);
    localparam logic           VS_ACT = (VS_POL != 0) ? 1'b1 : 1'b0;

    logic          vsa_q, vsa_d;
    logic          vsa_dly_q, vsa_dly_d;
    logic [WW-1:0] wd_cnt_q, wd_cnt_d;
    logic          err_q, err_d;

    always_comb begin
        vsa_d     = vsa;
        vsa_dly_d = vsa_q;
        fs        = (vsa_q == VS_ACT) && (vsa_dly_q != VS_ACT);
        wd_cnt_d  = wd_cnt_q;
        err_d     = err_q;
        if (!run || fs) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != WD_MAX) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
        if (run && (wd_cnt_q == WD_MAX)) begin
            err_d = 1'b1;
        end
        // A STOP landing on the same cycle as a saturated counter still clears.
        if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsa_q     <= ~VS_ACT;
            vsa_dly_q <= ~VS_ACT;
            wd_cnt_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            vsa_q     <= vsa_d;
            vsa_dly_q <= vsa_dly_d;
            wd_cnt_q  <= wd_cnt_d;
            err_q     <= err_d;
        end
    end

    assign timeout_err = err_q;

endmodule

// File: rtl/rgb_pattern_sequencer.sv
// Frame-level controller: gates the timing counter and picks the test pattern, changing only at frame start.
// One-deep command register: cmd_ready drops while a command waits for IDLE or the next frame start.
module rgb_pattern_sequencer
    import rgb_src_pkg::*;
#(
    parameter int NUM_PATTERNS = 8,
    parameter int PAT_W        = 3,
    parameter int HOLD_FRAMES  = 60,
    parameter int VS_POL       = 1,
    parameter int TIMEOUT      = 2000000
) (
    input  logic             Sys_Clock,
    input  logic             Reset,
    input  logic             VSA,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [PAT_W-1:0] cmd_pat,
    output logic             Timing_En,
    output logic [PAT_W-1:0] Pattern_Sel,
    output logic             Pattern_Upd,
    output logic [15:0]      Frame_Cnt,
    output logic             Timeout_Err
);
    localparam int               HW        = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_FRAMES - 1);
    localparam logic [PAT_W-1:0] PAT_MAX   = PAT_W'(NUM_PATTERNS - 1);
    localparam logic [PAT_W:0]   NP_EXT    = (PAT_W + 1)'(NUM_PATTERNS);

    function automatic logic [PAT_W-1:0] clamp(input logic [PAT_W-1:0] x);
        return ({1'b0, x} >= NP_EXT) ? PAT_MAX : x;
    endfunction

    function automatic logic [PAT_W-1:0] pat_inc(input logic [PAT_W-1:0] x);
        return (x == PAT_MAX) ? '0 : x + 1'b1;
    endfunction

    state_e           st_q, st_d, base_st;
    logic [PAT_W-1:0] pat_q, pat_d, base_pat;
    logic [HW-1:0]    hold_q, hold_d, base_hold;
    logic [15:0]      fcnt_q, fcnt_d;
    logic             ten_q, ten_d;
    logic             upd_q, upd_d;
    logic             arm_man_q, arm_man_d;
    logic [PAT_W-1:0] arm_pat_q, arm_pat_d;
    logic             pend_vld_q, pend_vld_d;
    op_e              pend_op_q, pend_op_d;
    logic [PAT_W-1:0] pend_pat_q, pend_pat_d;
    logic             fs, arm_load, err_clr;

    rgb_frame_tick #(
        .VS_POL  (VS_POL),
        .TIMEOUT (TIMEOUT)
    ) u_tick (
        .clk         (Sys_Clock),
        .rst_n       (Reset),
        .vsa         (VSA),
        .run         (st_q != IDLE),
        .err_clr     (err_clr),
        .fs          (fs),
        .timeout_err (Timeout_Err)
    );

    always_comb begin
        st_d       = st_q;
        pat_d      = pat_q;
        hold_d     = hold_q;
        fcnt_d     = fcnt_q;
        ten_d      = ten_q;
        arm_man_d  = arm_man_q;
        arm_pat_d  = arm_pat_q;
        pend_vld_d = pend_vld_q;
        pend_op_d  = pend_op_q;
        pend_pat_d = pend_pat_q;
        base_st    = st_q;
        base_pat   = pat_q;
        base_hold  = hold_q;
        arm_load   = 1'b0;
        err_clr    = 1'b0;

        if (cmd_valid && !pend_vld_q) begin
            pend_vld_d = 1'b1;
            pend_op_d  = op_e'(cmd_op);
            pend_pat_d = cmd_pat;
        end

        if (st_q == IDLE) begin
            if (pend_vld_q) begin
                pend_vld_d = 1'b0;
                if (pend_op_q == OP_RUN_AUTO || pend_op_q == OP_RUN_MANUAL) begin
                    ten_d     = 1'b1;
                    fcnt_d    = '0;
                    hold_d    = '0;
                    st_d      = ARM;
                    arm_man_d = (pend_op_q == OP_RUN_MANUAL);
                    arm_pat_d = clamp(pend_pat_q);
                end
            end
        end else if (fs) begin
            fcnt_d = fcnt_q + 16'd1;
            case (st_q)
                ARM: begin
                    base_st   = arm_man_q ? MANUAL : AUTO;
                    base_pat  = arm_man_q ? arm_pat_q : '0;
                    base_hold = '0;
                    arm_load  = 1'b1;
                end
                AUTO: begin
                    if (hold_q == HOLD_LAST) begin
                        base_hold = '0;
                        base_pat  = pat_inc(pat_q);
                    end else begin
                        base_hold = hold_q + 1'b1;
                    end
                end
                default: ;
            endcase
            st_d   = base_st;
            pat_d  = base_pat;
            hold_d = base_hold;

            // A pending command replaces whatever the frame boundary would have done.
            if (pend_vld_q) begin
                pend_vld_d = 1'b0;
                case (pend_op_q)
                    OP_STOP: begin
                        st_d     = IDLE;
                        ten_d    = 1'b0;
                        pat_d    = pat_q;
                        hold_d   = '0;
                        arm_load = 1'b0;
                        err_clr  = 1'b1;
                    end
                    OP_RUN_AUTO: begin
                        st_d   = AUTO;
                        pat_d  = '0;
                        hold_d = '0;
                    end
                    OP_RUN_MANUAL: begin
                        st_d  = MANUAL;
                        pat_d = clamp(pend_pat_q);
                    end
                    default: begin
                        pat_d  = pat_inc((st_q == ARM) ? base_pat : pat_q);
                        hold_d = '0;
                    end
                endcase
            end
        end

        upd_d = arm_load || (pat_d != pat_q);
    end

    always_ff @(posedge Sys_Clock or negedge Reset) begin
        if (!Reset) begin
            st_q       <= IDLE;
            pat_q      <= '0;
            hold_q     <= '0;
            fcnt_q     <= '0;
            ten_q      <= 1'b0;
            upd_q      <= 1'b0;
            arm_man_q  <= 1'b0;
            arm_pat_q  <= '0;
            pend_vld_q <= 1'b0;
            pend_op_q  <= OP_STOP;
            pend_pat_q <= '0;
        end else begin
            st_q       <= st_d;
            pat_q      <= pat_d;
            hold_q     <= hold_d;
            fcnt_q     <= fcnt_d;
            ten_q      <= ten_d;
            upd_q      <= upd_d;
            arm_man_q  <= arm_man_d;
            arm_pat_q  <= arm_pat_d;
            pend_vld_q <= pend_vld_d;
            pend_op_q  <= pend_op_d;
            pend_pat_q <= pend_pat_d;
        end
    end

    assign cmd_ready   = ~pend_vld_q;
    assign Timing_En   = ten_q;
    assign Pattern_Sel = pat_q;
    assign Pattern_Upd = upd_q;
    assign Frame_Cnt   = fcnt_q;

endmodule

// File: doc/rgb_pattern_sequencer.md
Name: rgb_pattern_sequencer

Overview:
- Frame-level controller for the RGB test source. It gates the sync/timing counter and selects which Data_patten pattern is shown.
- Pattern changes and start/stop happen only at frame boundaries, i.e. at the VSA assertion edge, so no frame is ever torn.
- Configuration arrives through a one-deep valid/ready command port. The block also supervises VSA with a frame watchdog.

Parameters:
- NUM_PATTERNS, 8: number of selectable patterns; legal indices are 0..NUM_PATTERNS-1.
- PAT_W, 3: width of the pattern index; must be >= clog2(NUM_PATTERNS).
- HOLD_FRAMES, 60: frames each pattern is held in AUTO mode; must be >= 1.
- VS_POL, 1: active level of VSA (1 = active-high).
- TIMEOUT, 2000000: Sys_Clock cycles allowed without a frame start before the error flag is set.

Ports:
- Sys_Clock, input, 1: the single system clock. All logic is on its rising edge.
- Reset, input, 1: asynchronous, active-low reset.
- VSA, input, 1: vertical sync from the timing counter.
- cmd_valid, input, 1: a command is presented.
- cmd_ready, output, 1: the block can accept a command.
- cmd_op, input, 2: 0 = STOP, 1 = RUN_AUTO, 2 = RUN_MANUAL, 3 = STEP.
- cmd_pat, input, PAT_W: pattern index carried by RUN_MANUAL.
- Timing_En, output, 1: enable for the sync/timing counter.
- Pattern_Sel, output, PAT_W: current pattern index sent to the pattern generator.
- Pattern_Upd, output, 1: one-cycle pulse on the cycle Pattern_Sel changes.
- Frame_Cnt, output, 16: frames seen since the last start.
- Timeout_Err, output, 1: sticky watchdog error flag.

Behaviour:
- Reset (async, Reset=0) values:
  - state = IDLE.
  - Timing_En=0, Pattern_Sel=0, Pattern_Upd=0, Frame_Cnt=0, Timeout_Err=0.
  - cmd_ready=1; the pending-command register and hold/watchdog counters are cleared.
  - Reset asserted mid-frame aborts everything immediately. No pending command survives.
- Frame start (fs):
  - VSA is registered once. fs = 1 for one cycle when the registered VSA transitions to the VS_POL level.
  - Latency: fs is one cycle after the VSA edge. All frame-boundary updates register on the fs cycle, so they are visible two cycles after the VSA edge.
- Command handshake:
  - Accept = cmd_valid & cmd_ready. The accepted op/pat is held in the pending register.
  - cmd_ready=0 while a command is pending.
  - In IDLE, a command is applied on the cycle after accept. In every other state it is applied at the next fs.
  - A command accepted on the same cycle as fs waits for the following fs.
  - cmd_ready returns to 1 on the cycle after the pending command is applied.
- States:
  - IDLE: Timing_En=0.
    - RUN_AUTO or RUN_MANUAL: Timing_En<=1, Frame_Cnt<=0, watchdog cleared, go to ARM.
    - STOP or STEP: consumed with no effect.
  - ARM: wait for the first fs.
    - At that fs, load Pattern_Sel (0 for AUTO, clamp(cmd_pat) for MANUAL) and pulse Pattern_Upd.
    - Go to AUTO or MANUAL accordingly.
  - AUTO: hold_cnt increments at each fs.
    - When hold_cnt == HOLD_FRAMES-1 at an fs: hold_cnt<=0, Pattern_Sel<=Pattern_Sel+1, pulse Pattern_Upd.
    - Pattern_Sel wraps from NUM_PATTERNS-1 to 0.
  - MANUAL: Pattern_Sel is held.
- Pending commands applied at fs in AUTO/MANUAL:
  - STOP: Timing_En<=0, go to IDLE, Timeout_Err<=0. Pattern_Sel is retained.
  - RUN_AUTO: go to AUTO, hold_cnt<=0, Pattern_Sel<=0.
  - RUN_MANUAL: go to MANUAL, Pattern_Sel<=clamp(cmd_pat).
  - STEP: Pattern_Sel+1 with wrap. In AUTO it also sets hold_cnt<=0.
  - A command applied at an fs overrides the AUTO hold advance on that same fs.
  - Pattern_Upd pulses only if Pattern_Sel actually changes value.
- clamp(x) = (x >= NUM_PATTERNS) ? NUM_PATTERNS-1 : x.
- Frame_Cnt: increments at each fs in ARM/AUTO/MANUAL. Wraps 0xFFFF to 0. Holds in IDLE.
- Watchdog:
  - Cycle counter runs in ARM/AUTO/MANUAL and clears at each fs. It saturates at TIMEOUT.
  - On reaching TIMEOUT: Timeout_Err<=1, sticky. State and outputs are otherwise unchanged.
  - Timeout_Err is cleared only by STOP or Reset.

Decomposition:
- Package rgb_src_pkg holds:
  - the cmd_op encodings (OP_STOP, OP_RUN_AUTO, OP_RUN_MANUAL, OP_STEP);
  - the state encoding (IDLE, ARM, AUTO, MANUAL).
- One sub-module, rgb_frame_tick: VSA register, polarity handling, fs pulse, and the watchdog counter with its timeout flag.
- Everything else (FSM, pending register, hold counter, Frame_Cnt) lives in the top module.

Test Plan:
- Reset release, then RUN_AUTO with HOLD_FRAMES=2, NUM_PATTERNS=3 -> Timing_En=1 next cycle. Pattern_Sel = 0,0,1,1,2,2,0 on successive frames; Pattern_Upd pulses only on the changes.
- RUN_MANUAL with cmd_pat=7, NUM_PATTERNS=5 -> Pattern_Sel=4 at the first fs. Then STEP -> 0 at the next fs.
- Command accepted on the same cycle as fs -> applied at the following fs. cmd_ready=0 until then; a second cmd_valid is stalled.
- STOP during AUTO mid-frame -> Timing_En stays 1 until the next fs, then 0. Pattern_Sel is retained and Frame_Cnt holds.
- VSA held static for TIMEOUT cycles in AUTO -> Timeout_Err=1 and sticky. STOP clears it.
- Reset asserted mid-frame with a command pending -> all outputs go to their reset values asynchronously and cmd_ready=1. After release the block stays in IDLE.
